// File: rtl/contador_cresc_5bits_pkg.sv
// rtl/contador_cresc_5bits_pkg.sv - shared constants and types for the 5-bit up counter
package contador_cresc_5bits_pkg;

  localparam int          CNT_W   = 5;
  localparam logic [4:0]  CNT_MAX = 5'd31;
  localparam logic [4:0]  CNT_RST = 5'd0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_WRAP,
    OP_LOAD
  } op_e;

  // Loaded values beyond the last legal count clamp to the last count.
  function automatic logic [CNT_W-1:0] sat_load(input logic [CNT_W-1:0] val,
                                                input logic [CNT_W-1:0] last);
    return (val > last) ? last : val;
  endfunction

endpackage

// File: rtl/contador_cresc_5bits_flipflopT_ar.sv
// rtl/contador_cresc_5bits_flipflopT_ar.sv - T flip-flop with asynchronous active-high clear
module flipflopT_ar (
  input  logic t,
  input  logic clk,
  input  logic clear,
  output logic q
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/contador_cresc_5bits.sv
// rtl/contador_cresc_5bits.sv - modulo-programmable 5-bit up counter on a T flip-flop chain
module contador_cresc_5bits
  import contador_cresc_5bits_pkg::*;
#(
  parameter int MODULO = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST = (MODULO >= 32) ? CNT_MAX : CNT_W'(MODULO - 1);

  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] chain;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] t;
  logic             at_last;
  op_e              op;

  assign at_last = (q == LAST);

  always_comb begin
    op = OP_HOLD;
    if (load)    op = OP_LOAD;
    else if (en) op = at_last ? OP_WRAP : OP_INC;

    chain[0] = 1'b1;
    for (int i = 1; i < CNT_W; i++) chain[i] = chain[i-1] & q[i-1];

    nxt = q;
    case (op)
      OP_LOAD: nxt = sat_load(load_val, LAST);
      OP_INC:  nxt = q ^ chain;
      OP_WRAP: nxt = CNT_RST;
      default: nxt = q;
    endcase

    // Every update, including load and wrap, is expressed as toggles on the same flops.
    t = q ^ nxt;
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_bit
    flipflopT_ar u_ff (
      .t     (t[i]),
      .clk   (clk),
      .clear (clear),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear)                 ovf <= 1'b0;
    else if (op == OP_LOAD)    ovf <= 1'b0;
    else if (op == OP_WRAP)    ovf <= 1'b1;
  end

  assign out = q;
  assign tc  = en & at_last;

endmodule

// File: tb/tb_contador_cresc_5bits.sv
// tb/tb_contador_cresc_5bits.sv - scoreboard bench for contador_cresc_5bits
module tb_contador_cresc_5bits;

  logic       clk = 1'b0;
  logic       clear;
  logic       en_a, ld_a, en_b, ld_b;
  logic       ld_c = 1'b0;
  logic [4:0] lv_a, lv_b;
  logic [4:0] lv_c = 5'd0;
  logic [4:0] out_a, out_b, out_c;
  logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  typedef struct {
    int         dut;
    int         tag;
    logic [4:0] out;
    logic       ovf;
    logic       tc;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  contador_cresc_5bits #(.MODULO(32)) u_a (
    .clk(clk), .clear(clear), .en(en_a), .load(ld_a), .load_val(lv_a),
    .out(out_a), .tc(tc_a), .ovf(ovf_a));

  contador_cresc_5bits #(.MODULO(10)) u_b (
    .clk(clk), .clear(clear), .en(en_b), .load(ld_b), .load_val(lv_b),
    .out(out_b), .tc(tc_b), .ovf(ovf_b));

  contador_cresc_5bits #(.MODULO(32)) u_c (
    .clk(clk), .clear(clear), .en(tc_a), .load(ld_c), .load_val(lv_c),
    .out(out_c), .tc(tc_c), .ovf(ovf_c));

  task automatic expect_v(input int dut, input int tag, input logic [4:0] o,
                          input logic ov, input logic t);
    exp_t e;
    e.dut = dut; e.tag = tag; e.out = o; e.ovf = ov; e.tc = t;
    q.push_back(e);
  endtask

  // Checks state between edges: record is consumed by the monitor without a clock.
  task automatic comb_check(input int dut, input int tag, input logic [4:0] o,
                            input logic ov, input logic t);
    #2;
    expect_v(dut, tag, o, ov, t);
    -> sample_ev;
    #2;
  endtask

  // Monitor: consume every queued expectation at each sample point.
  initial begin
    exp_t       e;
    logic [6:0] act, req;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.dut)
          0:       act = {out_a, ovf_a, tc_a};
          1:       act = {out_b, ovf_b, tc_b};
          default: act = {out_c, ovf_c, tc_c};
        endcase
        req = {e.out, e.ovf, e.tc};
        checks++;
        if (act === req) passed++;
        else $display("FAIL chk dut%0d tag%0d: out/ovf/tc actual=%0d/%0b/%0b required=%0d/%0b/%0b",
                      e.dut, e.tag, act[6:2], act[1], act[0], req[6:2], req[1], req[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1;
    en_a = 0; ld_a = 0; lv_a = 0;
    en_b = 0; ld_b = 0; lv_b = 0;
    #3;
    expect_v(0, 1, 5'd0, 0, 0);
    expect_v(1, 1, 5'd0, 0, 0);
    expect_v(2, 1, 5'd0, 0, 0);
    -> sample_ev;
    @(negedge clk);
    clear = 1'b0;

    // Count to 13, then clear asynchronously mid-count.
    for (int i = 0; i < 13; i++) begin
      en_a = 1;
      expect_v(0, 10 + i, 5'(i + 1), 0, 0);
      @(negedge clk);
    end
    clear = 1'b1;
    comb_check(0, 30, 5'd0, 0, 0);
    expect_v(0, 31, 5'd0, 0, 0);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_v(0, 40 + i, 5'(i + 1), 0, 0);
      @(negedge clk);
    end
    en_a = 0;
    clear = 1'b1; #1; clear = 1'b0;

    // Full 32-count with cascade observation.
    for (int i = 0; i < 32; i++) begin
      en_a = 1;
      expect_v(0, 100 + i, 5'((i + 1) % 32), (i == 31), (i == 30));
      expect_v(2, 200 + i, (i == 31) ? 5'd1 : 5'd0, 0, 0);
      @(negedge clk);
    end
    en_a = 0;
    expect_v(0, 300, 5'd0, 1, 0);
    @(negedge clk);

    // Hold: en toggles 1,0,1,0.
    en_a = 1; expect_v(0, 310, 5'd1, 1, 0); @(negedge clk);
    en_a = 0; expect_v(0, 311, 5'd1, 1, 0); @(negedge clk);
    en_a = 1; expect_v(0, 312, 5'd2, 1, 0); @(negedge clk);
    en_a = 0; expect_v(0, 313, 5'd2, 1, 0); @(negedge clk);

    // Advance to 7 with ovf still set, then load wins over en.
    en_a = 1;
    for (int i = 0; i < 5; i++) begin
      expect_v(0, 320 + i, 5'(3 + i), 1, 0);
      @(negedge clk);
    end
    ld_a = 1; lv_a = 5'd20;
    expect_v(0, 330, 5'd20, 0, 0);
    @(negedge clk);

    // Load versus wrap at 31.
    en_a = 0; lv_a = 5'd31;
    expect_v(0, 340, 5'd31, 0, 0);
    @(negedge clk);
    en_a = 1; lv_a = 5'd3;
    comb_check(0, 341, 5'd31, 0, 1);
    expect_v(0, 342, 5'd3, 0, 0);
    @(negedge clk);
    en_a = 0; ld_a = 0;

    // Cascade: second stage advances once per 32 counts.
    clear = 1'b1; #1; clear = 1'b0;
    en_a = 1;
    for (int i = 0; i < 64; i++) begin
      expect_v(2, 400 + i, 5'((i + 1) / 32), 0, 0);
      @(negedge clk);
    end
    en_a = 0;

    // MODULO=10 sequence and saturating load.
    for (int i = 0; i < 12; i++) begin
      en_b = 1;
      expect_v(1, 500 + i, 5'((i + 1) % 10), (i >= 9), (i == 8));
      @(negedge clk);
    end
    ld_b = 1; lv_b = 5'd20;
    expect_v(1, 520, 5'd9, 0, 1);
    @(negedge clk);
    en_b = 0; ld_b = 0;

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: pending=%0d required=0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
